// File: rtl/cpu_pkg.sv
// Shared types and constants for the ALU writeback stage: flag bit positions
// and the writeback FIFO entry layout.
package cpu_pkg;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int NREG = 2 ** AW;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-result input handshake and RF write port of the writeback stage.
// The master side is the ALU/RF environment; the slave side is the stage itself.
interface alu_writeback_if;
  import cpu_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_result;
  logic          in_z;
  logic          in_c;
  logic          in_n;
  logic [AW-1:0] in_rd;
  logic          in_wr_en;
  logic          in_flags_en;

  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic          rf_ready;

  modport master (
    output in_valid, in_result, in_z, in_c, in_n, in_rd, in_wr_en, in_flags_en,
    input  in_ready,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    output rf_ready
  );

  modport slave (
    input  in_valid, in_result, in_z, in_c, in_n, in_rd, in_wr_en, in_flags_en,
    output in_ready,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    input  rf_ready
  );

endinterface

// File: rtl/wb_fifo.sv
// Writeback FIFO: in-order storage of pending register writes, with a
// per-entry valid bit so the pending-destination mask is derived from state.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  wb_entry_t       entry_i,
  input  logic            pop_i,
  output wb_entry_t       head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [NREG-1:0] pend_mask_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    if (do_push) begin
      wr_ptr_d        = wr_ptr_q + PW'(1);
      vld_d[wr_ptr_q] = 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d        = rd_ptr_q + PW'(1);
      vld_d[rd_ptr_q] = 1'b0;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end
  end

  // Duplicate destinations simply OR together, so a bit stays set until the last one retires.
  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend_mask_o[mem_q[i].rd] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: architectural Z/C/N register plus a queued,
// backpressured register-file write port with a RAW pending mask.
module alu_writeback
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_writeback_if.slave  bus,
  input  logic            flag_ld,
  input  logic [2:0]      flag_ld_val,
  output logic            flag_z,
  output logic            flag_c,
  output logic            flag_n,
  output logic [NREG-1:0] pend_mask
);

  logic [2:0] flags_q, flags_d;
  logic       full, empty, accept, push, pop;
  wb_entry_t  new_entry, head;

  // in_ready comes only from registered occupancy, never from rf_ready.
  assign bus.in_ready = ~full;
  assign accept       = bus.in_valid & bus.in_ready;
  assign push         = accept & bus.in_wr_en;
  assign pop          = bus.rf_wr_en & bus.rf_ready;

  assign new_entry.rd   = bus.in_rd;
  assign new_entry.data = bus.in_result;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .entry_i     (new_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .pend_mask_o (pend_mask)
  );

  assign bus.rf_wr_en   = ~empty;
  assign bus.rf_wr_addr = head.rd;
  assign bus.rf_wr_data = head.data;

  // Interrupt restore wins over a same-cycle ALU flag update.
  always_comb begin
    flags_d = flags_q;
    if (flag_ld) begin
      flags_d = flag_ld_val;
    end else if (accept && bus.in_flags_en) begin
      flags_d[FLAG_Z] = bus.in_z;
      flags_d[FLAG_C] = bus.in_c;
      flags_d[FLAG_N] = bus.in_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flag_z = flags_q[FLAG_Z];
  assign flag_c = flags_q[FLAG_C];
  assign flag_n = flags_q[FLAG_N];

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based reference model of the writeback stage.
module tb_alu_writeback;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flag_ld = 1'b0;
  logic [2:0]      flag_ld_val = '0;
  logic            flag_z, flag_c, flag_n;
  logic [NREG-1:0] pend_mask;

  alu_writeback_if bus ();

  alu_writeback #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flag_ld     (flag_ld),
    .flag_ld_val (flag_ld_val),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_n      (flag_n),
    .pend_mask   (pend_mask)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending writes as a queue, flags as {n,c,z}.
  wb_entry_t  sb[$];
  logic [2:0] ref_flags = '0;

  always @(negedge clk) begin
    logic            exp_ready, acc;
    logic [NREG-1:0] exp_mask;
    wb_entry_t       e;
    if (!rst_n) begin
      sb.delete();
      ref_flags = '0;
    end else begin
      exp_ready = (sb.size() < DEPTH);
      chk("mon_in_ready", bus.in_ready, exp_ready);
      chk("mon_rf_wr_en", bus.rf_wr_en, sb.size() != 0);
      if (sb.size() != 0) begin
        chk("mon_rf_addr", bus.rf_wr_addr, sb[0].rd);
        chk("mon_rf_data", bus.rf_wr_data, sb[0].data);
      end
      exp_mask = '0;
      foreach (sb[i]) exp_mask = exp_mask | (NREG'(1) << sb[i].rd);
      chk("mon_pend_mask", pend_mask, exp_mask);
      chk("mon_flags", {flag_n, flag_c, flag_z}, ref_flags);

      if (sb.size() != 0 && bus.rf_ready) void'(sb.pop_front());
      acc = bus.in_valid && exp_ready;
      if (acc && bus.in_wr_en) begin
        e.rd   = bus.in_rd;
        e.data = bus.in_result;
        sb.push_back(e);
      end
      if (flag_ld)                  ref_flags = flag_ld_val;
      else if (acc && bus.in_flags_en) ref_flags = {bus.in_n, bus.in_c, bus.in_z};
    end
  end

  // Present one cycle of inputs, then return #1 after the edge that samples them.
  task automatic drive(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] res,
                       input logic [2:0] ncz, input logic we, input logic fe,
                       input logic fld, input logic [2:0] fldv, input logic rfr);
    bus.in_valid    = v;
    bus.in_rd       = rd;
    bus.in_result   = res;
    bus.in_n        = ncz[2];
    bus.in_c        = ncz[1];
    bus.in_z        = ncz[0];
    bus.in_wr_en    = we;
    bus.in_flags_en = fe;
    flag_ld         = fld;
    flag_ld_val     = fldv;
    bus.rf_ready    = rfr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rfr);
    drive(1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, rfr);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_rd = '0; bus.in_result = '0; bus.in_z = 0; bus.in_c = 0;
    bus.in_n = 0; bus.in_wr_en = 0; bus.in_flags_en = 0; bus.rf_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_rf_wr_en", bus.rf_wr_en, 1'b0);
    chk("rst_pend", pend_mask, 16'h0000);
    chk("rst_flags", {flag_n, flag_c, flag_z}, 3'b000);
    idle(1'b1);

    // Single write with one-cycle latency
    drive(1'b1, 4'd3, 32'h0000_0005, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    chk("single_wr_en", bus.rf_wr_en, 1'b1);
    chk("single_addr", bus.rf_wr_addr, 4'd3);
    chk("single_data", bus.rf_wr_data, 32'h5);
    chk("single_pend", pend_mask, 16'h0008);
    idle(1'b1);
    chk("single_clr_en", bus.rf_wr_en, 1'b0);
    chk("single_clr_pend", pend_mask, 16'h0000);

    // Carry chain: ADD 0xFFFFFFFF+1 -> 0 with c=1,z=1, then ADC sees c_in=1
    drive(1'b1, 4'd4, 32'h0, 3'b011, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    chk("carry_c", flag_c, 1'b1);
    chk("carry_z", flag_z, 1'b1);
    chk("carry_n", flag_n, 1'b0);
    drive(1'b1, 4'd5, 32'h0 + 32'h0 + {31'd0, flag_c}, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    chk("adc_result", bus.rf_wr_data, 32'h1);
    chk("adc_flags", {flag_n, flag_c, flag_z}, 3'b000);
    idle(1'b1);

    // Backpressure fill and in-order drain
    drive(1'b1, 4'd1, 32'h11, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 4'd2, 32'h22, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    chk("bp_pend", pend_mask, 16'h0006);
    chk("bp_head1", bus.rf_wr_addr, 4'd1);
    idle(1'b1);
    chk("bp_head2", bus.rf_wr_addr, 4'd2);
    chk("bp_data2", bus.rf_wr_data, 32'h22);
    chk("bp_ready_after_pop", bus.in_ready, 1'b1);
    idle(1'b1);
    chk("bp_empty", bus.rf_wr_en, 1'b0);

    // Simultaneous push+pop across pointer wrap, occupancy held at one
    drive(1'b1, 4'd7, 32'h70, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, AW'(8 + k), 32'h80 + k, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
      chk("wrap_count1_en", bus.rf_wr_en, 1'b1);
      chk("wrap_count1_pend", pend_mask, NREG'(1) << (8 + k));
      chk("wrap_data", bus.rf_wr_data, 32'h80 + k);
    end
    idle(1'b1);
    chk("wrap_empty", bus.rf_wr_en, 1'b0);

    // Flag load beats a simultaneous flag update
    drive(1'b1, 4'd0, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 3'b101, 1'b1);
    chk("flag_prio", {flag_n, flag_c, flag_z}, 3'b101);
    chk("flag_only_no_enq", bus.rf_wr_en, 1'b0);
    idle(1'b1);

    // Asynchronous reset mid-stream with two entries queued
    drive(1'b1, 4'd9, 32'h99, 3'b100, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 4'd10, 32'hAA, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rf_wr_en", bus.rf_wr_en, 1'b0);
    chk("arst_pend", pend_mask, 16'h0000);
    chk("arst_flags", {flag_n, flag_c, flag_z}, 3'b000);
    chk("arst_in_ready", bus.in_ready, 1'b1);
    idle(1'b1);
    idle(1'b1);
    rst_n = 1'b1;
    idle(1'b1);
    chk("arst_no_partial", bus.rf_wr_en, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, AW'($urandom), $urandom, 3'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0, 3'($urandom), $urandom_range(0, 9) < 7);
    end
    repeat (4) idle(1'b1);
    chk("final_drained", bus.rf_wr_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
